serial_maj_adder: RTL and testbench
===================================

SERIAL_MAJ_ADDER -- requirements
Module: serial_maj_adder

Interface
REQ-001 Parameter WIDTH, default 8, sets operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand set on a_in/b_in/cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a_in  input  WIDTH  addend A.
REQ-007 b_in  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result on sum/cout/ovf is valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  A+B+cin, low WIDTH bits.
REQ-012 cout  output  1  final carry.
REQ-013 ovf  output  1  two's-complement overflow.
REQ-014 busy  output  1  high in RUN.

Function
REQ-015 The block SHALL be a bit-serial adder with states IDLE, RUN and DONE, processing one bit per clock, LSB first.
REQ-016 Each RUN cycle SHALL compute s_i = a_i XOR b_i XOR c_i and c_(i+1) = MAJ(a_i, b_i, c_i) = (a_i AND b_i) OR (a_i AND c_i) OR (b_i AND c_i), with c_0 = cin.
REQ-017 The carry SHALL be held in a 1-bit register between bits; the only combinational carry logic is one 3-input majority.
REQ-018 in_ready SHALL equal 1 exactly when the state is IDLE.
REQ-019 On an edge with in_valid=1 and in_ready=1, the block SHALL capture a_in, b_in and cin into shift registers, clear the bit counter and enter RUN.
REQ-020 While in RUN, in_valid SHALL be ignored and a_in, b_in and cin SHALL NOT be sampled.
REQ-021 Each RUN edge SHALL shift in one sum bit at the MSB of the sum register, shift A and B right, increment the counter and update the carry.
REQ-022 After the WIDTH-th RUN edge, the block SHALL enter DONE, so out_valid rises WIDTH cycles after the accept edge.
REQ-023 In DONE, out_valid SHALL be 1 and sum, cout and ovf SHALL stay stable until the out_ready=1 edge.
REQ-024 The out_ready=1 edge SHALL return the block to IDLE; the next operand set is accepted no earlier than the following edge (no same-cycle turnaround).
REQ-025 cout SHALL be c_WIDTH.
REQ-026 ovf SHALL be c_(WIDTH-1) XOR c_WIDTH, which requires the carry into the MSB to be registered.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 WIDTH=1 SHALL work: one RUN cycle, with ovf = cin XOR cout.
REQ-029 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap during RUN.
REQ-030 sum SHALL hold the previous result in IDLE and RUN; consumers rely on it only while out_valid=1.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE and in_ready=1, with out_valid, busy, sum, cout, ovf, carry, counter and the shift registers all 0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately and discard it, with no out_valid pulse afterward.
REQ-033 After rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Verification
REQ-034 WIDTH=8, A=0xFF, B=0x01, cin=0 -> after 8 cycles, out_valid=1, sum=0x00, cout=1, ovf=0.
REQ-035 WIDTH=8, A=0x7F, B=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; then A=0xFF, B=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> next cycle IDLE with in_ready=1.
REQ-037 in_valid pulsed mid-RUN with different operands -> result unaffected and no second operation starts.
REQ-038 rst_n low at RUN bit 4 -> all outputs 0 while low; after release, A=0x05, B=0x03, cin=0 -> sum=0x08, cout=0.
REQ-039 WIDTH=1, all 8 combinations of a, b, cin -> sum, cout and ovf match the truth table, each with latency 1.

Source files
------------

// File: rtl/serial_maj_adder.sv
// Bit-serial two's-complement adder, one bit per clock LSB first; result valid WIDTH cycles after accept.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no same-cycle turnaround).
module serial_maj_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic [WIDTH-1:0] w_sum_next;

   // One full-adder slice; the carry lives in r_carry between bits.
   assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_sum_next            = r_sum >> 1;
      w_sum_next[WIDTH-1]   = w_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_next = ST_RUN;
         ST_RUN:  if (w_last)    w_next = ST_DONE;
         ST_DONE: if (out_ready) w_next = ST_IDLE;
         default:                w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= w_sum_next;
               r_carry <= w_c;
               r_cnt   <= r_cnt + CW'(1);
               // On the MSB slice r_carry is c_(WIDTH-1) and w_c is c_WIDTH.
               if (w_last) begin
                  r_cout <= w_c;
                  r_ovf  <= r_carry ^ w_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);
   assign out_valid = (r_state == ST_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_maj_adder.sv
// Bench for serial_maj_adder: WIDTH=8 and WIDTH=1 instances, table vectors plus scoreboard.
module tb_serial_maj_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       of;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      exp_t       e;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       iv8, or8, cin8;
   logic [7:0] a8, b8;
   logic       ir8, ov8, co8, of8, bz8;
   logic [7:0] s8;

   logic       iv1, or1, cin1;
   logic [0:0] a1, b1;
   logic       ir1, ov1, co1, of1, bz1;
   logic [0:0] s1;

   serial_maj_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
      .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
   );

   serial_maj_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1),
      .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1), .busy(bz1)
   );

   logic       sel;
   wire        m_ir  = sel ? ir1 : ir8;
   wire        m_ov  = sel ? ov1 : ov8;
   wire        m_bz  = sel ? bz1 : bz8;
   wire        m_co  = sel ? co1 : co8;
   wire        m_of  = sel ? of1 : of8;
   wire [7:0]  m_sum = sel ? {7'b0, s1} : s8;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   vec_t v8[10];
   vec_t v1[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
      if (sel) begin
         iv1 = v; a1 = a[0]; b1 = b[0]; cin1 = c;
      end else begin
         iv8 = v; a8 = a; b8 = b; cin8 = c;
      end
   endtask

   task automatic set_ordy(input logic r);
      if (sel) or1 = r;
      else     or8 = r;
   endtask

   function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] full;
      exp_t       e;
      full = {1'b0, a} + {1'b0, b} + {8'b0, c};
      e.s  = full[7:0];
      e.co = full[8];
      e.of = (a[7] == b[7]) && (full[7] != a[7]);
      return e;
   endfunction

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, input exp_t e,
                        input int hold, input bit early, input bit pulse);
      int         lat;
      exp_t       ex;
      logic [7:0] s0;
      logic       co0, of0;
      lat = 0;
      while (!m_ir && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("in_ready before op", m_ir, 1);
      sb.push_back(e);
      drive(1'b1, a, b, c);
      set_ordy(early);
      @(negedge clk);
      drive(1'b0, ~a, ~b, ~c);
      check("busy/in_ready after accept", {m_bz, m_ir}, 2'b10);
      lat = 0;
      while (!m_ov && lat < 50) begin
         if (pulse && lat == 2) drive(1'b1, a ^ 8'h5A, b ^ 8'hC3, ~c);
         else                   drive(1'b0, ~a, ~b, ~c);
         @(negedge clk);
         lat++;
      end
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("latency", lat, sel ? 1 : 8);
      if (sb.size() == 0) begin
         check("scoreboard has entry", 0, 1);
      end else begin
         ex = sb.pop_front();
         check("sum", m_sum, ex.s);
         check("cout", m_co, ex.co);
         check("ovf", m_of, ex.of);
      end
      s0 = m_sum; co0 = m_co; of0 = m_of;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold in DONE", {m_ov, m_ir, m_sum, m_co, m_of}, {1'b1, 1'b0, s0, co0, of0});
      end
      set_ordy(1'b1);
      @(negedge clk);
      check("return to IDLE", {m_ov, m_ir, m_bz}, 3'b010);
      set_ordy(1'b0);
      if (pulse) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no second op", {m_bz, m_ov, m_ir}, 3'b001);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      v8[0] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
      v8[1] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
      v8[2] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
      v8[3] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};
      v8[4] = '{8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0}};
      v8[5] = '{8'h55, 8'hAA, 1'b0, '{8'hFF, 1'b0, 1'b0}};
      v8[6] = '{8'h3C, 8'h0F, 1'b1, '{8'h4C, 1'b0, 1'b0}};
      v8[7] = '{8'h80, 8'hFF, 1'b0, '{8'h7F, 1'b1, 1'b1}};
      v8[8] = '{8'h40, 8'h40, 1'b0, '{8'h80, 1'b0, 1'b1}};
      v8[9] = '{8'h12, 8'h34, 1'b1, '{8'h47, 1'b0, 1'b0}};

      v1[0] = '{8'h0, 8'h0, 1'b0, '{8'h0, 1'b0, 1'b0}};
      v1[1] = '{8'h0, 8'h0, 1'b1, '{8'h1, 1'b0, 1'b1}};
      v1[2] = '{8'h0, 8'h1, 1'b0, '{8'h1, 1'b0, 1'b0}};
      v1[3] = '{8'h0, 8'h1, 1'b1, '{8'h0, 1'b1, 1'b0}};
      v1[4] = '{8'h1, 8'h0, 1'b0, '{8'h1, 1'b0, 1'b0}};
      v1[5] = '{8'h1, 8'h0, 1'b1, '{8'h0, 1'b1, 1'b0}};
      v1[6] = '{8'h1, 8'h1, 1'b0, '{8'h0, 1'b1, 1'b1}};
      v1[7] = '{8'h1, 8'h1, 1'b1, '{8'h1, 1'b1, 1'b0}};

      rst_n = 1'b0;
      sel   = 1'b0;
      iv8 = 1'b0; or8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      iv1 = 1'b0; or1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      #2;
      check("reset state w8", {ir8, ov8, bz8, s8, co8, of8}, {3'b100, 8'h00, 2'b00});
      check("reset state w1", {ir1, ov1, bz1, s1, co1, of1}, {3'b100, 1'b0, 2'b00});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_op(v8[i].a, v8[i].b, v8[i].c, v8[i].e, (i == 1) ? 5 : 0, (i == 2), (i == 3));
      end

      // Abort mid-RUN with a nonzero held sum, then accept on the first edge after release.
      drive(1'b1, 8'h12, 8'h34, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      check("busy before reset", m_bz, 1);
      rst_n = 1'b0;
      #1;
      check("outputs during reset", {m_ir, m_ov, m_bz, m_sum, m_co, m_of}, {3'b100, 8'h00, 2'b00});
      @(negedge clk);
      check("outputs still in reset", {m_ir, m_ov, m_bz, m_sum, m_co, m_of}, {3'b100, 8'h00, 2'b00});
      rst_n = 1'b1;
      do_op(8'h05, 8'h03, 1'b0, '{8'h08, 1'b0, 1'b0}, 0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         do_op(ra, rb, rc, model8(ra, rb, rc), i % 3, 1'b0, 1'b0);
      end

      sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_op(v1[i].a, v1[i].b, v1[i].c, v1[i].e, (i == 5) ? 2 : 0, 1'b0, 1'b0);
      end

      check("scoreboard drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
